poly_compressor: RTL

- Upstream counterpart of the 3-bit ciphertext decompressor. It reads N polynomial coefficients (mod q) from the poly RAM and compresses each to 3 bits.
- It packs each group of 8 results into 3 bytes and writes 3N/8 bytes to the byte RAM. This is exactly the byte layout the decompressor consumes.
- It streams at one coefficient per cycle.

---
 rtl/poly_compressor_if.sv | 26 ++
 rtl/poly_compressor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/poly_compressor_if.sv
// Purpose: handshake, poly-RAM read and byte-RAM write signals of the 3-bit coefficient compressor.
// Ports: start/busy/done control; poly_addrb/poly_dob read port; byte_wea/byte_addr/byte_di write port.
// master = compressor side, slave = environment side (controller plus both RAMs).
interface poly_compressor_if #(
  parameter int PA_W = 9,
  parameter int BA_W = 10
);
  logic            start;
  logic            busy;
  logic            done;
  logic [PA_W-1:0] poly_addrb;
  logic [15:0]     poly_dob;
  logic            byte_wea;
  logic [BA_W-1:0] byte_addr;
  logic [7:0]      byte_di;

  modport master (
    input  start, poly_dob,
    output busy, done, poly_addrb, byte_wea, byte_addr, byte_di
  );

  modport slave (
    output start, poly_dob,
    input  busy, done, poly_addrb, byte_wea, byte_addr, byte_di
  );
endinterface

// File: rtl/poly_compressor.sv
// Purpose: read N coefficients mod Q, round each to 3 bits and pack 8 results into 3 bytes.
// Latency: one coefficient per cycle; done pulses N+2 cycles after the start is accepted.
// Backpressure: none; the block streams freely, and start is honoured only while IDLE.
// Ports: clk, rst (async, active-high); bus.start/busy/done control; bus.poly_addrb -> bus.poly_dob
//        read port with a 1-cycle synchronous RAM; bus.byte_wea/byte_addr/byte_di byte-RAM write port.
module poly_compressor #(
  parameter int Q        = 12289,
  parameter int N        = 512,
  parameter int OUT_BASE = 0
) (
  input logic               clk,
  input logic               rst,
  poly_compressor_if.master bus
);
  localparam int PA_W = $clog2(N);
  localparam int BA_W = 10;
  localparam logic [BA_W-1:0] BASE = BA_W'(OUT_BASE);
  localparam logic [PA_W-1:0] LAST = PA_W'(N - 1);
  localparam logic [13:0]     Q14  = 14'(Q);

  // Smallest t for which ((8t + Q/2) div Q) >= k, i.e. the decision threshold for level k.
  // Level 8 wraps back to 0.
  function automatic logic [13:0] thr(input int k);
    return 14'((k * Q - Q / 2 + 7) / 8);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t          state_q, state_d;
  logic [PA_W-1:0] addr_q, addr_d;
  // rd_vld_q/rd_idx_q track which coefficient is currently presented on poly_dob.
  logic            rd_vld_q, rd_vld_d;
  logic [2:0]      rd_idx_q, rd_idx_d;
  // Only the result bits still needed by a later byte are kept.
  logic [2:0]      r0_q, r0_d, r1_q, r1_d, r3_q, r3_d, r4_q, r4_d, r6_q, r6_d;
  logic            r2h_q, r2h_d;
  logic [1:0]      r5h_q, r5h_d;
  logic            wea_q, wea_d;
  logic [7:0]      di_q, di_d;
  logic [BA_W-1:0] baddr_q, baddr_d;
  logic [BA_W-1:0] nxt_q, nxt_d;

  logic [13:0] x, t;
  logic [2:0]  r_now;
  logic [1:0]  unused_dob;

  assign x          = bus.poly_dob[13:0];
  assign unused_dob = bus.poly_dob[15:14];
  assign t          = (x >= Q14) ? (x - Q14) : x;

  // Compare against each threshold; the highest one passed wins.
  always_comb begin
    r_now = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      if (t >= thr(k)) r_now = 3'(k);
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rd_vld_d = 1'b0;
    rd_idx_d = rd_idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          addr_d   = '0;
          rd_idx_d = 3'd0;
        end
      end
      RUN: begin
        rd_vld_d = 1'b1;
        rd_idx_d = addr_q[2:0];
        if (addr_q == LAST) state_d = DRAIN;
        else                addr_d  = addr_q + 1'b1;
      end
      // The last coefficient is on poly_dob now; its byte write is registered at this edge.
      DRAIN:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2h_d   = r2h_q;
    r3_d    = r3_q;
    r4_d    = r4_q;
    r5h_d   = r5h_q;
    r6_d    = r6_q;
    wea_d   = 1'b0;
    di_d    = di_q;
    baddr_d = baddr_q;
    nxt_d   = nxt_q;
    if (state_q == IDLE && bus.start) nxt_d = BASE;
    if (rd_vld_q) begin
      unique case (rd_idx_q)
        3'd0: r0_d = r_now;
        3'd1: r1_d = r_now;
        3'd2: begin
          r2h_d = r_now[2];
          wea_d = 1'b1;
          di_d  = {r_now[1:0], r1_q, r0_q};
        end
        3'd3: r3_d = r_now;
        3'd4: r4_d = r_now;
        3'd5: begin
          r5h_d = r_now[2:1];
          wea_d = 1'b1;
          di_d  = {r_now[0], r4_q, r3_q, r2h_q};
        end
        3'd6: r6_d = r_now;
        3'd7: begin
          wea_d = 1'b1;
          di_d  = {r_now, r6_q, r5h_q};
        end
        default: ;
      endcase
    end
    if (wea_d) begin
      baddr_d = nxt_q;
      nxt_d   = nxt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= 3'd0;
      r0_q     <= 3'd0;
      r1_q     <= 3'd0;
      r2h_q    <= 1'b0;
      r3_q     <= 3'd0;
      r4_q     <= 3'd0;
      r5h_q    <= 2'd0;
      r6_q     <= 3'd0;
      wea_q    <= 1'b0;
      di_q     <= 8'd0;
      baddr_q  <= BASE;
      nxt_q    <= BASE;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_vld_q <= rd_vld_d;
      rd_idx_q <= rd_idx_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
      r2h_q    <= r2h_d;
      r3_q     <= r3_d;
      r4_q     <= r4_d;
      r5h_q    <= r5h_d;
      r6_q     <= r6_d;
      wea_q    <= wea_d;
      di_q     <= di_d;
      baddr_q  <= baddr_d;
      nxt_q    <= nxt_d;
    end
  end

  assign bus.busy       = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done       = (state_q == FINISH);
  assign bus.poly_addrb = addr_q;
  assign bus.byte_wea   = wea_q;
  assign bus.byte_addr  = baddr_q;
  assign bus.byte_di    = di_q;
endmodule
